sipo_test: RTL and testbench
============================

// Module: sipo_test
// PURPOSE
//  Self-contained serial-in/parallel-out test block. Snapshots a parallel word and
//  serialises its low 25 bits on out_sel with a strobe on clk_sel. An internal SIPO
//  deserialises the stream into five 5-bit output lanes, then raises finished.
//  Used as an on-chip loopback check of a serial link.
// PARAMETERS
//  DATA_W  32  width of DATA input
//  N_OUT   5   number of parallel output lanes
//  OUT_W   5   bits per lane; TX_BITS = N_OUT*OUT_W = 25 (must be <= DATA_W)
// PORTS
//  clk       in   1       single clock, all logic on rising edge
//  rst       in   1       synchronous, active-low reset
//  DATA      in   DATA_W  word to transmit; sampled once per transfer
//  clk_sel   out  1       serial strobe (registered): 0 = bit setup, 1 = bit valid
//  out_sel   out  1       serial data (registered), MSB first
//  out1..out5 out OUT_W   received lanes; out1 = least significant
//  finished  out  1       transfer complete, lanes valid
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): state=LOAD; clk_sel=0, out_sel=0, out1..out5=0,
//    finished=0, shift reg=0, bit index=TX_BITS-1. Reset mid-transfer aborts it;
//    the next transfer restarts from LOAD.
//  - FSM states: LOAD, SH_LO, SH_HI, DONE.
//    LOAD  (1 cycle): tx_q<=DATA[TX_BITS-1:0]; out_sel<=tx_q MSB (bit 24);
//          clk_sel<=0; go to SH_HI.
//    SH_HI: clk_sel<=1; out_sel held; go to SH_LO.
//    SH_LO: the SIPO shifts in out_sel (registered clk_sel==1 this edge).
//          If bit index==0: clk_sel<=0, out_sel<=0, go to DONE.
//          Otherwise: decrement index, out_sel<=next bit, clk_sel<=0, go to SH_HI.
//  - Each bit occupies 2 clk cycles (setup, valid). DATA changes after LOAD are ignored.
//  - SIPO: 25-bit register, shift left, serial bit inserted at LSB, on edges where
//    registered clk_sel==1. After 25 shifts it equals DATA[24:0].
//  - DONE entry edge: out_k <= sr[5k-1 -: 5] (out1=sr[4:0] .. out5=sr[24:20]);
//    finished<=1. Lanes are only updated here, never mid-transfer.
//  - Timing, counting edge 1 as the first edge with rst==1:
//    bit 24 driven after edge 1; bit i sampled at edge 2*(24-i)+3;
//    last sample at edge 51; finished=1 and lanes valid after edge 52.
//  - DATA[DATA_W-1:TX_BITS] is unused.
// CONFIGURATION
//  SIPO_AUTO_RESTART_EN defined: DONE lasts 1 cycle; finished is a 1-cycle pulse;
//    FSM returns to LOAD and re-snapshots DATA. Lanes hold between updates.
//  Not defined: DONE is terminal; finished stays 1 and lanes hold until reset.
// STRUCTURE
//  Package sipo_test_pkg: state enum {LOAD,SH_LO,SH_HI,DONE}; constants DATA_W,
//    N_OUT, OUT_W, TX_BITS.
//  Sub-module sipo_shift_reg (WIDTH=TX_BITS; ports clk, rst, en, din, q):
//    receive shift register. Top holds the FSM, tx snapshot, index counter and
//    output lane registers.
// TESTING
//  1. DATA=32'h2180_8218; rst low 3 cycles, then high -> after edge 52:
//     out5=5'b11000, out4=5'b00001, out3=5'b00000, out2=5'b10000,
//     out1=5'b11000, finished=1.
//  2. Same run: out_sel sequence sampled while clk_sel==1 =
//     1100000001000001000011000 (25 bits); clk_sel toggles with a 2-cycle period.
//  3. DATA=32'hFFFF_FFFF -> all lanes = 5'h1F. DATA=32'hFE00_0000 -> all lanes 0
//     (upper bits ignored). finished=1 after edge 52 in both cases.
//  4. Drive rst low at edge 20 of a transfer -> all outputs 0 next edge. Release
//     rst -> fresh transfer; finished again 52 edges later with correct lanes.
//  5. Change DATA at edge 10 -> lanes reflect the value sampled at LOAD only.
//  6. SIPO_AUTO_RESTART_EN defined -> finished pulses 1 cycle every 52 cycles;
//     lanes track DATA per transfer. Not defined -> finished stays 1 for 200 cycles.

Source files
------------

// File: rtl/sipo_test_pkg.sv
// ============================================================================
// Module : sipo_test_pkg
// Brief  : Shared sizing constants and FSM state encoding for the SIPO loopback block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sipo_test_pkg;

   localparam int DATA_W  = 32;
   localparam int N_OUT   = 5;
   localparam int OUT_W   = 5;
   localparam int TX_BITS = N_OUT * OUT_W;
   localparam int IDX_W   = $clog2(TX_BITS);

   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TX_BITS - 1);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SH_LO = 2'd1,
      SH_HI = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sipo_shift_reg.sv
// ============================================================================
// Module : sipo_shift_reg
// Brief  : Receive shift register; shifts left with the serial bit entering at the LSB.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_shift_reg #(
   parameter int WIDTH = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= '0;
      end else if (en) begin
         q <= {q[WIDTH-2:0], din};
      end
   end

endmodule

`default_nettype wire

// File: rtl/sipo_test.sv
// ============================================================================
// Module : sipo_test
// Brief  : Serialises DATA[24:0] MSB first with a setup/valid strobe and loops it back
//          through a SIPO into five 5-bit lanes. SIPO_AUTO_RESTART_EN repeats transfers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_test
   import sipo_test_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] DATA,
   output logic              clk_sel,
   output logic              out_sel,
   output logic [OUT_W-1:0]  out1,
   output logic [OUT_W-1:0]  out2,
   output logic [OUT_W-1:0]  out3,
   output logic [OUT_W-1:0]  out4,
   output logic [OUT_W-1:0]  out5,
   output logic              finished
);

   state_t               state_q;
   logic [TX_BITS-1:0]   tx_q;
   logic [IDX_W-1:0]     idx_q;
   logic                 clk_sel_q;
   logic                 out_sel_q;
   logic                 finished_q;
   logic [OUT_W-1:0]     lane_q [N_OUT];
   logic [TX_BITS-1:0]   sr_q;
   logic [IDX_W-1:0]     idx_d;
   logic                 unused_data_hi;

   assign idx_d          = idx_q - IDX_W'(1);
   assign unused_data_hi = ^DATA[DATA_W-1:TX_BITS];

   // The receiver samples on the registered strobe, so a bit is captured on the
   // edge that ends its valid phase.
   sipo_shift_reg #(
      .WIDTH (TX_BITS)
   ) u_rx_sr (
      .clk (clk),
      .rst (rst),
      .en  (clk_sel_q),
      .din (out_sel_q),
      .q   (sr_q)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= LOAD;
         tx_q       <= '0;
         idx_q      <= IDX_MAX;
         clk_sel_q  <= 1'b0;
         out_sel_q  <= 1'b0;
         finished_q <= 1'b0;
         for (int k = 0; k < N_OUT; k++) begin
            lane_q[k] <= '0;
         end
      end else begin
         case (state_q)
            LOAD: begin
               tx_q       <= DATA[TX_BITS-1:0];
               out_sel_q  <= DATA[TX_BITS-1];
               clk_sel_q  <= 1'b0;
               idx_q      <= IDX_MAX;
               finished_q <= 1'b0;
               state_q    <= SH_HI;
            end
            SH_HI: begin
               clk_sel_q <= 1'b1;
               state_q   <= SH_LO;
            end
            SH_LO: begin
               clk_sel_q <= 1'b0;
               if (idx_q == '0) begin
                  out_sel_q <= 1'b0;
                  state_q   <= DONE;
               end else begin
                  idx_q     <= idx_d;
                  out_sel_q <= tx_q[idx_d];
                  state_q   <= SH_HI;
               end
            end
            DONE: begin
               // Lanes latch only on the first DONE cycle of a transfer.
               if (!finished_q) begin
                  for (int k = 0; k < N_OUT; k++) begin
                     lane_q[k] <= sr_q[k*OUT_W +: OUT_W];
                  end
               end
`ifdef SIPO_AUTO_RESTART_EN
               finished_q <= 1'b1;
               state_q    <= LOAD;
`else
               finished_q <= 1'b1;
               state_q    <= DONE;
`endif
            end
            default: begin
               state_q <= LOAD;
            end
         endcase
      end
   end

   assign clk_sel  = clk_sel_q;
   assign out_sel  = out_sel_q;
   assign finished = finished_q;
   assign out1     = lane_q[0];
   assign out2     = lane_q[1];
   assign out3     = lane_q[2];
   assign out4     = lane_q[3];
   assign out5     = lane_q[4];

endmodule

`default_nettype wire

// File: tb/tb_sipo_test.sv
// ============================================================================
// Module : tb_sipo_test
// Brief  : Directed self-checking bench for sipo_test (honours SIPO_AUTO_RESTART_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sipo_test;

   logic        clk;
   logic        rst;
   logic [31:0] DATA;
   logic        clk_sel;
   logic        out_sel;
   logic [4:0]  out1, out2, out3, out4, out5;
   logic        finished;

   int n_tests = 0;
   int n_fail  = 0;

   sipo_test dut (
      .clk      (clk),
      .rst      (rst),
      .DATA     (DATA),
      .clk_sel  (clk_sel),
      .out_sel  (out_sel),
      .out1     (out1),
      .out2     (out2),
      .out3     (out3),
      .out4     (out4),
      .out5     (out5),
      .finished (finished)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [24:0] lanes();
      return {out5, out4, out3, out2, out1};
   endfunction

   // Holds rst low for n edges, checks the cleared outputs, and leaves rst low
   // just after an edge so the caller's release makes the next edge "edge 1".
   task automatic do_reset(input int n);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      check_eq("reset lanes",    lanes(),  25'h0);
      check_eq("reset finished", finished, 1'b0);
      check_eq("reset strobe",   {clk_sel, out_sel}, 2'b00);
   endtask

   // Runs edges 1..52 of a transfer, optionally changing DATA after chg_e.
   task automatic run_xfer(input logic [31:0] d, input logic [24:0] exp, input string tag,
                           input int chg_e, input logic [31:0] chg_d);
      logic [24:0] bits;
      int          clk_err;
      int          n_bits;
      bits    = '0;
      clk_err = 0;
      n_bits  = 0;
      DATA    = d;
      rst     = 1'b1;
      for (int e = 1; e <= 52; e++) begin
         @(posedge clk); #1;
         if (clk_sel !== ((e % 2 == 0) && (e <= 50))) clk_err++;
         if (clk_sel === 1'b1) begin
            bits = {bits[23:0], out_sel};
            n_bits++;
         end
         if (e == chg_e) DATA = chg_d;
         if (e == 51) check_eq({tag, " finished early"}, finished, 1'b0);
      end
      check_eq({tag, " serial bits"},  bits,    exp);
      check_eq({tag, " bit count"},    n_bits,  25);
      check_eq({tag, " clk_sel shape"}, clk_err, 0);
      check_eq({tag, " finished"},     finished, 1'b1);
      check_eq({tag, " lanes"},        lanes(),  exp);
   endtask

   initial begin
      int hold_err;
      rst  = 1'b0;
      DATA = '0;

      // Spec example word, lane by lane.
      do_reset(3);
      run_xfer(32'h2180_8218, 25'b1100000001000001000011000, "ex", 0, 32'h0);
      check_eq("ex out5", out5, 5'b11000);
      check_eq("ex out4", out4, 5'b00001);
      check_eq("ex out3", out3, 5'b00000);
      check_eq("ex out2", out2, 5'b10000);
      check_eq("ex out1", out1, 5'b11000);

      do_reset(3);
      run_xfer(32'hFFFF_FFFF, 25'h1FF_FFFF, "ones", 0, 32'h0);
      do_reset(3);
      run_xfer(32'hFE00_0000, 25'h0, "upper", 0, 32'h0);

      // Mid-transfer abort: out_sel is 1 after edge 19 for an all-ones word.
      do_reset(3);
      DATA = 32'hFFFF_FFFF;
      rst  = 1'b1;
      repeat (19) @(posedge clk);
      #1;
      check_eq("pre-abort out_sel", out_sel, 1'b1);
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("abort strobe",   {clk_sel, out_sel}, 2'b00);
      check_eq("abort finished", finished, 1'b0);
      check_eq("abort lanes",    lanes(), 25'h0);
      repeat (2) @(posedge clk);
      #1;
      run_xfer(32'h0155_AAAA, {5'h15, 5'h0B, 5'h0A, 5'h15, 5'h0A}, "restart", 0, 32'h0);

      // DATA change after the snapshot must not reach the lanes.
      do_reset(3);
      run_xfer(32'h0123_4567, {5'h12, 5'h06, 5'h11, 5'h0B, 5'h07}, "late", 10, 32'h00AA_AAAA);

`ifdef SIPO_AUTO_RESTART_EN
      do_reset(3);
      run_xfer(32'h0123_4567, {5'h12, 5'h06, 5'h11, 5'h0B, 5'h07}, "auto1", 0, 32'h0);
      DATA = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      check_eq("auto pulse width", finished, 1'b0);
      hold_err = 0;
      for (int e = 54; e <= 103; e++) begin
         @(posedge clk); #1;
         if (finished !== 1'b0) hold_err++;
         if (lanes() !== {5'h12, 5'h06, 5'h11, 5'h0B, 5'h07}) hold_err++;
      end
      check_eq("auto hold between", hold_err, 0);
      @(posedge clk); #1;
      check_eq("auto2 finished", finished, 1'b1);
      check_eq("auto2 lanes",    lanes(),  25'h1FF_FFFF);
`else
      hold_err = 0;
      DATA = 32'h0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (finished !== 1'b1) hold_err++;
         if (lanes() !== {5'h12, 5'h06, 5'h11, 5'h0B, 5'h07}) hold_err++;
      end
      check_eq("terminal hold", hold_err, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
